// File: rtl/ex_mem_pkg.sv
// Shared pipeline-register definitions: stall vector indices and the
// per-edge action decoded from reset/flush/stall.
package ex_mem_pkg;

    localparam int STALL_W   = 6;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    // One-hot so each action is a single observable bit.
    typedef enum logic [3:0] {
        ACT_CLEAR  = 4'b0001,
        ACT_HOLD   = 4'b0010,
        ACT_BUBBLE = 4'b0100,
        ACT_LOAD   = 4'b1000
    } pipe_act_e;

endpackage

// File: rtl/ex_mem_if.sv
// Execute-to-memory bundle: execute results in, registered stage contents
// and accumulate state out.
interface ex_mem_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    // No valid/ready pair here: the producer presents ex_* every cycle, and
    // the stall vector is the only back-pressure. stall[4] freezes the stage,
    // stall[3] alone turns the next capture into a bubble (mem_valid=0),
    // and flush overrides both.
    logic [5:0]      stall;
    logic            flush;
    logic [AW-1:0]   ex_wd;
    logic            ex_wreg;
    logic [DW-1:0]   ex_wdata;
    logic            ex_whilo;
    logic [DW-1:0]   ex_hi;
    logic [DW-1:0]   ex_lo;
    logic [2*DW-1:0] hilo_temp_i;
    logic [1:0]      cnt_i;

    logic [AW-1:0]   mem_wd;
    logic            mem_wreg;
    logic [DW-1:0]   mem_wdata;
    logic            mem_whilo;
    logic [DW-1:0]   mem_hi;
    logic [DW-1:0]   mem_lo;
    logic            mem_valid;
    logic [2*DW-1:0] hilo_temp_o;
    logic [1:0]      cnt_o;

    modport master (
        output stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
               hilo_temp_i, cnt_i,
        input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               mem_valid, hilo_temp_o, cnt_o
    );

    modport slave (
        input  stall, flush, ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
               hilo_temp_i, cnt_i,
        output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
               mem_valid, hilo_temp_o, cnt_o
    );

endinterface

// File: rtl/pipe_ctl.sv
// Decodes reset/flush and the stall bits of this stage and the next one
// into a one-hot action for a pipeline register.
module pipe_ctl
    import ex_mem_pkg::*;
(
    input  logic      rst,
    input  logic      flush,
    input  logic      stall_cur,
    input  logic      stall_next,
    output pipe_act_e act
);

    // Priority: clear, then hold (downstream stalled), then bubble.
    always_comb begin
        act = ACT_LOAD;
        if (rst || flush) begin
            act = ACT_CLEAR;
        end else if (stall_next) begin
            act = ACT_HOLD;
        end else if (stall_cur) begin
            act = ACT_BUBBLE;
        end
    end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register of the MIPS32 core, including the accumulate
// state that execute loops back through this stage while it is stalled.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic   clk,
    input  logic   rst,
    ex_mem_if.slave bus
);

    pipe_act_e act;
    logic      unused_stall;

    assign unused_stall = ^{bus.stall[2:0], bus.stall[5]};

    pipe_ctl u_pipe_ctl (
        .rst        (rst),
        .flush      (bus.flush),
        .stall_cur  (bus.stall[STALL_EX]),
        .stall_next (bus.stall[STALL_MEM]),
        .act        (act)
    );

    always_ff @(posedge clk) begin
        case (act)
            ACT_CLEAR: begin
                bus.mem_wd      <= '0;
                bus.mem_wreg    <= 1'b0;
                bus.mem_wdata   <= '0;
                bus.mem_whilo   <= 1'b0;
                bus.mem_hi      <= '0;
                bus.mem_lo      <= '0;
                bus.mem_valid   <= 1'b0;
                bus.hilo_temp_o <= '0;
                bus.cnt_o       <= '0;
            end
            ACT_HOLD: begin
            end
            ACT_BUBBLE: begin
                // Bubble carries no write, but the accumulate step advances.
                bus.mem_wd      <= '0;
                bus.mem_wreg    <= 1'b0;
                bus.mem_wdata   <= '0;
                bus.mem_whilo   <= 1'b0;
                bus.mem_hi      <= '0;
                bus.mem_lo      <= '0;
                bus.mem_valid   <= 1'b0;
                bus.hilo_temp_o <= bus.hilo_temp_i;
                bus.cnt_o       <= bus.cnt_i;
            end
            default: begin
                bus.mem_wd      <= bus.ex_wd;
                bus.mem_wreg    <= bus.ex_wreg;
                bus.mem_wdata   <= bus.ex_wdata;
                bus.mem_whilo   <= bus.ex_whilo;
                bus.mem_hi      <= bus.ex_hi;
                bus.mem_lo      <= bus.ex_lo;
                bus.mem_valid   <= 1'b1;
                bus.hilo_temp_o <= '0;
                bus.cnt_o       <= '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: vector table, hand-written accumulate/reset sequences
// and a randomised phase, all checked through an expected-value queue.
module tb_ex_mem;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = AW + 1 + DW + 1 + DW + DW + 1 + 2*DW + 2;

    typedef struct {
        logic            rst;
        logic            flush;
        logic [5:0]      stall;
        logic [AW-1:0]   wd;
        logic            wreg;
        logic [DW-1:0]   wdata;
        logic            whilo;
        logic [DW-1:0]   hi;
        logic [DW-1:0]   lo;
        logic [2*DW-1:0] ht;
        logic [1:0]      cnt;
        logic [OW-1:0]   exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_if #(.DW(DW), .AW(AW)) bus ();

    ex_mem #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    vec_t          vecs[$];
    logic [OW-1:0] model;

    function automatic logic [OW-1:0] pk(
        input logic [AW-1:0] wd, input logic wreg, input logic [DW-1:0] wdata,
        input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo,
        input logic valid, input logic [2*DW-1:0] ht, input logic [1:0] cnt);
        return {wd, wreg, wdata, whilo, hi, lo, valid, ht, cnt};
    endfunction

    function automatic vec_t mk(
        input logic r, input logic f, input logic [5:0] st,
        input logic [AW-1:0] wd, input logic wreg, input logic [DW-1:0] wdata,
        input logic whilo, input logic [DW-1:0] hi, input logic [DW-1:0] lo,
        input logic [2*DW-1:0] ht, input logic [1:0] cnt, input logic [OW-1:0] e);
        vec_t v;
        v.rst = r; v.flush = f; v.stall = st; v.wd = wd; v.wreg = wreg;
        v.wdata = wdata; v.whilo = whilo; v.hi = hi; v.lo = lo;
        v.ht = ht; v.cnt = cnt; v.exp = e;
        return v;
    endfunction

    function automatic logic [OW-1:0] dut_out();
        return {bus.mem_wd, bus.mem_wreg, bus.mem_wdata, bus.mem_whilo,
                bus.mem_hi, bus.mem_lo, bus.mem_valid, bus.hilo_temp_o, bus.cnt_o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        rst             = v.rst;
        bus.flush       = v.flush;
        bus.stall       = v.stall;
        bus.ex_wd       = v.wd;
        bus.ex_wreg     = v.wreg;
        bus.ex_wdata    = v.wdata;
        bus.ex_whilo    = v.whilo;
        bus.ex_hi       = v.hi;
        bus.ex_lo       = v.lo;
        bus.hilo_temp_i = v.ht;
        bus.cnt_i       = v.cnt;
    endtask

    task automatic check_edge(input string name);
        logic [OW-1:0] e;
        logic [OW-1:0] a;
        @(posedge clk);
        #1;
        n_checks++;
        a = dut_out();
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got %h but no expected value queued", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", name, a, e);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        drive(v);
        exp_q.push_back(v.exp);
        check_edge(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [OW-1:0] zero;
        logic [OW-1:0] e;
        logic [31:0]   r;
        vec_t          v;
        int            mode;
        zero = '0;

        drive(mk(1'b1, 1'b0, 6'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0, zero));

        // reset with nonzero inputs, then first pass-through
        vecs.push_back(mk(1'b1, 1'b0, 6'b000000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'h2,
                          64'h3, 2'd2, zero));
        vecs.push_back(mk(1'b1, 1'b0, 6'b000000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'h2,
                          64'h3, 2'd2, zero));
        vecs.push_back(mk(1'b0, 1'b0, 6'b000000, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0,
                          64'h0, 2'd0,
                          pk(5'd5, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0)));
        // bubble, then hold keeps bubble + accumulate state
        vecs.push_back(mk(1'b0, 1'b0, 6'b001111, 5'd3, 1'b1, 32'h55, 1'b1, 32'h4, 32'h6,
                          64'h0000_0001_0000_0002, 2'd1,
                          pk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0000_0001_0000_0002, 2'd1)));
        vecs.push_back(mk(1'b0, 1'b0, 6'b011111, 5'd9, 1'b1, 32'h66, 1'b0, 32'h0, 32'h0,
                          64'h9, 2'd2,
                          pk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0000_0001_0000_0002, 2'd1)));
        // load AAAA_0000 then hold for 3 cycles while ex_wdata changes
        vecs.push_back(mk(1'b0, 1'b0, 6'b000000, 5'd7, 1'b1, 32'hAAAA_0000, 1'b0, 32'h0, 32'h0,
                          64'h5, 2'd3,
                          pk(5'd7, 1'b1, 32'hAAAA_0000, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0)));
        for (int k = 1; k <= 3; k++) begin
            vecs.push_back(mk(1'b0, 1'b0, 6'b011111, 5'd8, 1'b0, 32'(k), 1'b1, 32'h3, 32'h3,
                              64'h1, 2'd1,
                              pk(5'd7, 1'b1, 32'hAAAA_0000, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0)));
        end
        // flush beats hold
        vecs.push_back(mk(1'b0, 1'b0, 6'b000000, 5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h11, 32'h22,
                          64'h0, 2'd0,
                          pk(5'd9, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h11, 32'h22, 1'b1, 64'h0, 2'd0)));
        vecs.push_back(mk(1'b0, 1'b1, 6'b011111, 5'd2, 1'b1, 32'h1, 1'b1, 32'h1, 32'h1,
                          64'h4, 2'd1, zero));
        // illegal stall 010000 still holds
        vecs.push_back(mk(1'b0, 1'b0, 6'b000000, 5'd4, 1'b1, 32'hCAFE, 1'b1, 32'h1, 32'h2,
                          64'h0, 2'd0,
                          pk(5'd4, 1'b1, 32'hCAFE, 1'b1, 32'h1, 32'h2, 1'b1, 64'h0, 2'd0)));
        vecs.push_back(mk(1'b0, 1'b0, 6'b010000, 5'd6, 1'b0, 32'hBAD, 1'b0, 32'h9, 32'h9,
                          64'h8, 2'd3,
                          pk(5'd4, 1'b1, 32'hCAFE, 1'b1, 32'h1, 32'h2, 1'b1, 64'h0, 2'd0)));
        // flush aborts an in-flight bubble/accumulate
        vecs.push_back(mk(1'b0, 1'b1, 6'b001111, 5'd6, 1'b1, 32'h77, 1'b1, 32'h9, 32'h9,
                          64'h8, 2'd2, zero));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // two-step accumulate: bubble edge with cnt=1, then pass with HI/LO write
        apply(mk(1'b0, 1'b0, 6'b001111, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
                 64'h0000_0003_0000_0004, 2'd1,
                 pk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0000_0003_0000_0004, 2'd1)),
              "accum_step1");
        apply(mk(1'b0, 1'b0, 6'b000000, 5'd0, 1'b0, 32'h0, 1'b1, 32'h7, 32'h9,
                 64'h0000_0003_0000_0004, 2'd2,
                 pk(5'd0, 1'b0, 32'h0, 1'b1, 32'h7, 32'h9, 1'b1, 64'h0, 2'd0)),
              "accum_step2");

        // reset asserted mid-accumulate
        apply(mk(1'b0, 1'b0, 6'b001111, 5'd1, 1'b1, 32'h5, 1'b0, 32'h0, 32'h0,
                 64'h77, 2'd1,
                 pk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h77, 2'd1)),
              "rst_mid_accum_a");
        apply(mk(1'b1, 1'b0, 6'b001111, 5'd1, 1'b1, 32'h5, 1'b0, 32'h0, 32'h0,
                 64'h78, 2'd2, zero),
              "rst_mid_accum_b");
        apply(mk(1'b0, 1'b0, 6'b000000, 5'd1, 1'b1, 32'h11, 1'b0, 32'h0, 32'h0,
                 64'h0, 2'd0,
                 pk(5'd1, 1'b1, 32'h11, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0)),
              "after_rst_load");
        model = pk(5'd1, 1'b1, 32'h11, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0);

        // randomised mix; also confirms outputs do not follow inputs mid-cycle
        for (int n = 0; n < 24; n++) begin
            mode = int'($urandom_range(0, 9));
            r = $urandom;
            v.rst = 1'b0;
            v.flush = (mode == 0);
            v.stall = (mode == 1) ? 6'b011111 : (mode <= 3) ? 6'b001111 : 6'b000000;
            v.wd = r[4:0];
            v.wreg = r[5];
            v.whilo = r[6];
            v.cnt = r[8:7];
            v.wdata = $urandom;
            v.hi = $urandom;
            v.lo = $urandom;
            v.ht = {$urandom, $urandom};
            if (mode == 0)      e = zero;
            else if (mode == 1) e = model;
            else if (mode <= 3) e = pk(5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, v.ht, v.cnt);
            else                e = pk(v.wd, v.wreg, v.wdata, v.whilo, v.hi, v.lo, 1'b1, 64'h0, 2'd0);
            v.exp = e;
            @(negedge clk);
            drive(v);
            #1;
            n_checks++;
            if (dut_out() !== model) begin
                n_fail++;
                $display("FAIL rnd%0d_no_comb: got %h expected %h", n, dut_out(), model);
            end
            exp_q.push_back(e);
            check_edge($sformatf("rnd%0d", n));
            model = e;
        end

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem.md
# ex_mem

Pipeline register between the execute stage and the memory stage of the 5-stage MIPS32 core. It captures the execute result, destination register, write-enable and HI/LO write request on each clock edge. It honours the global stall vector and flush. It also holds the multi-cycle accumulate state (`hilo_temp`, `cnt`) that the execute stage needs across stalled cycles for madd/msub-class instructions.

## Interface
Parameters:
- `DW`, 32, data word width (`RegBus`)
- `AW`, 5, register address width (`RegAddrBus`)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `stall`  in  6  global stall vector: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
- `flush`  in  1  exception flush; kill stage content
- `ex_wd`  in  AW  destination register from execute
- `ex_wreg`  in  1  register write enable from execute
- `ex_wdata`  in  DW  result from execute
- `ex_whilo`  in  1  HI/LO write enable from execute
- `ex_hi`, `ex_lo`  in  DW each  HI/LO values from execute
- `hilo_temp_i`  in  2*DW  partial accumulate product from execute
- `cnt_i`  in  2  execute multi-cycle step counter
- `mem_wd`  out  AW  registered destination
- `mem_wreg`  out  1  registered write enable
- `mem_wdata`  out  DW  registered result
- `mem_whilo`  out  1  registered HI/LO write enable
- `mem_hi`, `mem_lo`  out  DW each  registered HI/LO
- `mem_valid`  out  1  1 = stage holds a real instruction, 0 = bubble
- `hilo_temp_o`  out  2*DW  returned to execute; accumulate state
- `cnt_o`  out  2  returned to execute; step counter

## Operation
- All outputs are registered; there is no combinational path from input to output.
- Per rising edge, first matching rule wins:
  1. `rst`=1: all outputs 0.
  2. `flush`=1: all outputs 0, same as reset. This also aborts a multi-cycle accumulate in flight.
  3. `stall[4]`=1: hold every output, including `hilo_temp_o`/`cnt_o`.
  4. `stall[3]`=1 (and `stall[4]`=0): insert a bubble.
     - `mem_wd`, `mem_wreg`, `mem_wdata`, `mem_whilo`, `mem_hi`, `mem_lo`, `mem_valid` go to 0.
     - `hilo_temp_o`←`hilo_temp_i`, `cnt_o`←`cnt_i`. This lets execute advance its step while stalled.
  5. Otherwise, pass through:
     - `mem_*`←`ex_*`, `mem_valid`←1.
     - `hilo_temp_o`←0, `cnt_o`←0.
- `stall[3]`=0 with `stall[4]`=1 is illegal, because the stall vector is monotonic. Rule 3 still applies: hold.
- A bubble must never assert `mem_wreg` or `mem_whilo`.
- `mem_wdata` is carried unmodified, with no width change or sign handling.

## Timing
- Latency is 1 cycle from `ex_*` to `mem_*` when neither stall bit is set.
- The accumulate state loop is execute → `hilo_temp_i` → register → `hilo_temp_o` → execute. A value written during a stall cycle is seen by execute in the next cycle.
- A two-step accumulate takes 2 edges:
  - Edge 1: execute raises `stall[3]` with `cnt_i`=1; this block captures `cnt_o`=1.
  - Edge 2: execute drops the stall; the result passes through and `cnt_o` clears to 0.
- Reset asserted mid-accumulate takes effect on the next edge: `cnt_o`=0 and `hilo_temp_o`=0.
- Flush and stall in the same cycle: flush wins.
- Reset values: every output is 0, including `mem_valid`.

## Structure
- The shared defines header supplies the following; do not redeclare them locally:
  - `RegBus`, `RegAddrBus`, `DoubleRegBus`, `ZeroWord`
  - `RstEnable`, `Stop`/`NoStop`
  - `WriteEnable`/`WriteDisable`
- The stall-bit indices (`STALL_EX`=3, `STALL_MEM`=4) are added to the same header, because the other pipeline registers use them too.
- One optional sub-module, `pipe_ctl`, decodes (`rst`, `flush`, `stall[n]`, `stall[n+1]`) into one-hot {clear, hold, bubble, load}. It is reused by `if_id`, `id_ex` and `mem_wb`.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with nonzero inputs → all outputs 0 and `mem_valid`=0; after release, `ex_wd`=5, `ex_wdata`=0x1234_5678, `ex_wreg`=1 → next edge `mem_wd`=5, `mem_wdata`=0x1234_5678, `mem_wreg`=1, `mem_valid`=1.
- Bubble: `stall`=6'b001111, `ex_wreg`=1, `cnt_i`=1, `hilo_temp_i`=0x0000_0001_0000_0002 → `mem_wreg`=0, `mem_valid`=0, `cnt_o`=1, `hilo_temp_o`=0x0000_0001_0000_0002.
- Hold: load `mem_wdata`=0xAAAA_0000, then `stall`=6'b011111 for 3 cycles while `ex_wdata` changes → `mem_wdata` stays 0xAAAA_0000 and `cnt_o` is unchanged.
- Accumulate sequence: bubble edge with `cnt_i`=1, then pass edge with `ex_whilo`=1, `ex_hi`=7, `ex_lo`=9 → `mem_whilo`=1, `mem_hi`=7, `mem_lo`=9, `cnt_o`=0, `hilo_temp_o`=0.
- Flush priority: `flush`=1 together with `stall`=6'b011111 and stage loaded → all outputs 0 on the next edge.
- Illegal stall: `stall`=6'b010000 → outputs held. Separately, assert `rst` during an accumulate with `cnt_o`=1 → `cnt_o`=0 on the next edge.
